zx_vram_arbiter: RTL

- Sits between zx_ula's timing/CPU decode logic and the external 512K video/main SRAM (va/vd/n_vrd/n_vwr).
- Time-multiplexes the single SRAM port between two clients:
  - screen fetch of bitmap and attribute bytes for the pixel shifter (ULA video path);
  - CPU read/write requests issued by the ULA memory decoder.
- Video fetches have fixed, guaranteed slots. CPU accesses take the remaining slots; pending accesses are held until served.

---
 rtl/zx_vram_pkg.sv | 30 +++
 rtl/zx_vram_if.sv | 33 +++
 rtl/zx_vram_arbiter_screen_addr.sv | 23 ++
 rtl/zx_vram_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/zx_vram_pkg.sv
// Shared types and constants for the ZX video/main SRAM arbiter.
// Screen addresses are a bank base plus a 13-bit offset inside the 16K bank.
package zx_vram_pkg;

    localparam int CHAR_CYCLES = 16;
    localparam int ACC_CYCLES  = 4;

    localparam logic [18:0] BANK5    = 19'h14000;
    localparam logic [18:0] BANK7    = 19'h1C000;
    localparam logic [12:0] BMP_OFS  = 13'h0000;
    localparam logic [12:0] ATTR_OFS = 13'h1800;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_DONE
    } slot_state_e;

    typedef enum logic [1:0] {
        CL_BMP,
        CL_ATTR,
        CL_CPU
    } client_e;

    function automatic logic [18:0] bank_base(input logic page);
        return page ? BANK7 : BANK5;
    endfunction

endpackage

// File: rtl/zx_vram_if.sv
// ULA-side bundle: beam timing, CPU request/response and video fetch results.
// master = ULA decoder/timing, slave = the arbiter.
interface zx_vram_if;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic [3:0]  char_phase;
    logic        screen_fetch;
    logic        screen_page;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [7:0]  vid_bitmap;
    logic [7:0]  vid_attr;
    logic        vid_valid;

    modport master (
        output hc, vc, char_phase, screen_fetch, screen_page,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_ack, cpu_rdata,
        input  vid_bitmap, vid_attr, vid_valid
    );

    modport slave (
        input  hc, vc, char_phase, screen_fetch, screen_page,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_ack, cpu_rdata,
        output vid_bitmap, vid_attr, vid_valid
    );
endinterface

// File: rtl/zx_vram_arbiter_screen_addr.sv
// Combinational screen address generator: bitmap and attribute byte
// addresses for the character cell under the beam.
module zx_screen_addr
    import zx_vram_pkg::*;
(
    input  logic [4:0]  hc_cell,
    input  logic [7:0]  vc_line,
    input  logic        screen_page,
    output logic [18:0] bmp_addr,
    output logic [18:0] attr_addr
);

    logic [12:0] bmp_ofs;
    logic [12:0] attr_ofs;

    // Bitmap rows are interleaved: third, pixel row, character row, column.
    assign bmp_ofs   = BMP_OFS  | {vc_line[7:6], vc_line[2:0], vc_line[5:3], hc_cell};
    assign attr_ofs  = ATTR_OFS | {3'b000, vc_line[7:3], hc_cell};

    assign bmp_addr  = bank_base(screen_page) | {6'b0, bmp_ofs};
    assign attr_addr = bank_base(screen_page) | {6'b0, attr_ofs};

endmodule

// File: rtl/zx_vram_arbiter.sv
// Single-port SRAM arbiter: fixed bitmap/attribute slots for the video path,
// remaining 4-clock slots go to a one-entry CPU request holding register.
module zx_vram_arbiter
    import zx_vram_pkg::*;
(
    input  logic        clk28,
    input  logic        rst_n,
    zx_vram_if.slave    vif,
    output logic [18:0] va,
    inout  wire  [7:0]  vd,
    output logic        n_vrd,
    output logic        n_vwr
);

    slot_state_e state_q, state_d;
    client_e     client_q, client_d;
    logic [18:0] va_q, va_d;

    logic        fetch_cell_q;
    logic [18:0] attr_addr_q;

    logic        busy_q;
    logic        we_q;
    logic [18:0] addr_q;
    logic [7:0]  wdata_q;
    logic        ack_q;
    logic [7:0]  rdata_q;

    logic [7:0]  bmp_hold_q;
    logic [7:0]  bitmap_q;
    logic [7:0]  attr_q;
    logic        valid_q;

    logic [18:0] bmp_addr;
    logic [18:0] attr_addr;
    logic        slot_start;
    logic [3:0]  slot_idx;
    logic        cpu_pending;
    logic        cpu_write;
    logic        in_strobe;
    logic        unused_cnt_bits;

    assign unused_cnt_bits = ^{vif.hc[8], vif.hc[2:0], vif.vc[8]};

    zx_screen_addr u_screen_addr (
        .hc_cell     (vif.hc[7:3]),
        .vc_line     (vif.vc[7:0]),
        .screen_page (vif.screen_page),
        .bmp_addr    (bmp_addr),
        .attr_addr   (attr_addr)
    );

    assign slot_start  = ((int'(vif.char_phase) % ACC_CYCLES) == 0);
    assign slot_idx    = vif.char_phase / 4'(ACC_CYCLES);
    // A strobe arriving in the slot-start cycle is served straight from the ports.
    assign cpu_pending = busy_q | vif.cpu_req;

    always_comb begin
        state_d  = state_q;
        client_d = client_q;
        va_d     = va_q;
        case (state_q)
            ST_IDLE: begin
                if (slot_start) begin
                    if ((slot_idx == 4'd0) && vif.screen_fetch) begin
                        state_d  = ST_ADDR;
                        client_d = CL_BMP;
                        va_d     = bmp_addr;
                    end else if ((slot_idx == 4'd1) && fetch_cell_q) begin
                        state_d  = ST_ADDR;
                        client_d = CL_ATTR;
                        va_d     = attr_addr_q;
                    end else if (cpu_pending) begin
                        state_d  = ST_ADDR;
                        client_d = CL_CPU;
                        va_d     = busy_q ? addr_q : vif.cpu_addr;
                    end
                end
            end
            ST_ADDR:   state_d = ST_STROBE;
            ST_STROBE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            client_q     <= CL_CPU;
            va_q         <= '0;
            fetch_cell_q <= 1'b0;
            attr_addr_q  <= '0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            bmp_hold_q   <= '0;
            bitmap_q     <= '0;
            attr_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            client_q <= client_d;
            va_q     <= va_d;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;

            // Cell-level decisions are frozen at phase 0 so mid-cell changes wait a cell.
            if (vif.char_phase == 4'd0) begin
                fetch_cell_q <= vif.screen_fetch;
                attr_addr_q  <= attr_addr;
            end

            if (vif.cpu_req && !busy_q) begin
                busy_q  <= 1'b1;
                we_q    <= vif.cpu_we;
                addr_q  <= vif.cpu_addr;
                wdata_q <= vif.cpu_wdata;
            end

            if (state_q == ST_DONE) begin
                case (client_q)
                    CL_BMP:  bmp_hold_q <= vd;
                    CL_ATTR: begin
                        bitmap_q <= bmp_hold_q;
                        attr_q   <= vd;
                        valid_q  <= 1'b1;
                    end
                    CL_CPU: begin
                        ack_q  <= 1'b1;
                        busy_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= vd;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cpu_write = (client_q == CL_CPU) && we_q;
    assign in_strobe = (state_q == ST_STROBE) || (state_q == ST_DONE);

    assign va    = va_q;
    assign n_vrd = !(in_strobe && !cpu_write);
    assign n_vwr = !((state_q == ST_STROBE) && cpu_write);
    assign vd    = (in_strobe && cpu_write) ? wdata_q : 8'bz;

    assign vif.cpu_busy   = busy_q;
    assign vif.cpu_ack    = ack_q;
    assign vif.cpu_rdata  = rdata_q;
    assign vif.vid_bitmap = bitmap_q;
    assign vif.vid_attr   = attr_q;
    assign vif.vid_valid  = valid_q;

endmodule
